// File: rtl/energy_acc_pkg.sv
// Shared types and constants for the energy accumulator.
// Optional peak tracking is enabled with the PEAK_TRACK_EN macro in the users of this package.
package energy_acc_pkg;

    localparam int ENERGY_W = 32;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Unsigned add that clamps at all-ones instead of wrapping.
    function automatic logic [ENERGY_W-1:0] sat_add(
        input logic [ENERGY_W-1:0] a,
        input logic [ENERGY_W-1:0] b
    );
        logic [ENERGY_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ENERGY_W] ? '1 : s[ENERGY_W-1:0];
    endfunction

endpackage

// File: rtl/energy_acc_chan.sv
// Per-channel window storage: running sum, sample count and (with PEAK_TRACK_EN) running peak.
// The window closes on the accept that finds the count at all-ones; storage clears on that same edge.
module energy_acc_chan
    import energy_acc_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int WIN_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_acc,
    input  logic [DATA_W-1:0]          i_data,
    output logic [DATA_W+WIN_LOG2-1:0] o_sum_next,
    output logic                       o_last
`ifdef PEAK_TRACK_EN
    ,
    output logic [DATA_W-1:0]          o_peak_next
`endif
);

    localparam int SUM_W = DATA_W + WIN_LOG2;

    logic [SUM_W-1:0]    r_sum;
    logic [WIN_LOG2-1:0] r_cnt;

    assign o_sum_next = r_sum + SUM_W'(i_data);
    assign o_last     = &r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (i_acc) begin
            if (o_last) begin
                r_sum <= '0;
                r_cnt <= '0;
            end else begin
                r_sum <= o_sum_next;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef PEAK_TRACK_EN
    logic [DATA_W-1:0] r_peak;

    assign o_peak_next = (i_data > r_peak) ? i_data : r_peak;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_peak <= '0;
        end else if (i_acc) begin
            r_peak <= o_last ? '0 : o_peak_next;
        end
    end
`endif

endmodule

// File: rtl/energy_accumulator.sv
// Multi-channel windowed power averager with threshold alarm and saturating energy total.
// Define PEAK_TRACK_EN to add the r_peak output (window maximum presented with r_avg).
//   state | meaning
//   ACCUM | no result pending, r_valid=0
//   HOLD  | result held on r_ch/r_avg/r_alarm until r_ready, r_valid=1
module energy_accumulator
    import energy_acc_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_CH   = 4,
    parameter int WIN_LOG2 = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [$clog2(NUM_CH)-1:0] s_ch,
    input  logic [DATA_W-1:0]         s_data,
    input  logic [DATA_W-1:0]         threshold,
    output logic                      r_valid,
    input  logic                      r_ready,
    output logic [$clog2(NUM_CH)-1:0] r_ch,
    output logic [DATA_W-1:0]         r_avg,
    output logic                      r_alarm,
`ifdef PEAK_TRACK_EN
    output logic [DATA_W-1:0]         r_peak,
`endif
    output logic [ENERGY_W-1:0]       energy_total
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int SUM_W = DATA_W + WIN_LOG2;

    state_t              r_state;
    state_t              w_state_next;
    logic [ENERGY_W-1:0] r_energy;

    logic               w_ch_ok;
    logic               w_acc;
    logic               w_done;
    logic [NUM_CH-1:0]  w_acc_ch;
    logic [NUM_CH-1:0]  w_last;
    logic [SUM_W-1:0]   w_sum_next [NUM_CH];
    logic [SUM_W-1:0]   w_sum_sel;
    logic               w_last_sel;
    logic [DATA_W-1:0]  w_avg_new;

    // Out-of-range channel indices never reach storage and never count as accepts.
    assign w_ch_ok   = ({1'b0, s_ch} < (CH_W+1)'(NUM_CH));
    assign s_ready   = !r_valid || r_ready;
    assign w_acc     = s_valid && s_ready && w_ch_ok;
    assign w_done    = w_acc && w_last_sel;
    assign w_avg_new = w_sum_sel[SUM_W-1:WIN_LOG2];

`ifdef PEAK_TRACK_EN
    logic [DATA_W-1:0] w_peak_next [NUM_CH];
    logic [DATA_W-1:0] w_peak_sel;
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_chan
            assign w_acc_ch[g] = w_acc && (s_ch == CH_W'(g));

            energy_acc_chan #(
                .DATA_W   (DATA_W),
                .WIN_LOG2 (WIN_LOG2)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .i_acc       (w_acc_ch[g]),
                .i_data      (s_data),
                .o_sum_next  (w_sum_next[g]),
                .o_last      (w_last[g])
`ifdef PEAK_TRACK_EN
                ,
                .o_peak_next (w_peak_next[g])
`endif
            );
        end
    endgenerate

    always_comb begin
        w_sum_sel  = '0;
        w_last_sel = 1'b0;
`ifdef PEAK_TRACK_EN
        w_peak_sel = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (s_ch == CH_W'(i)) begin
                w_sum_sel  = w_sum_next[i];
                w_last_sel = w_last[i];
`ifdef PEAK_TRACK_EN
                w_peak_sel = w_peak_next[i];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A completion in HOLD is only possible when r_ready frees the slot, so HOLD is kept.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM:   if (w_done) w_state_next = HOLD;
            HOLD:    if (r_ready && !w_done) w_state_next = ACCUM;
            default: w_state_next = ACCUM;
        endcase
    end

    always_comb begin
        r_valid = (r_state == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch    <= '0;
            r_avg   <= '0;
            r_alarm <= 1'b0;
`ifdef PEAK_TRACK_EN
            r_peak  <= '0;
`endif
        end else if (w_done) begin
            r_ch    <= s_ch;
            r_avg   <= w_avg_new;
            r_alarm <= (w_avg_new > threshold);
`ifdef PEAK_TRACK_EN
            r_peak  <= w_peak_sel;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_energy <= '0;
        end else if (w_acc) begin
            r_energy <= sat_add(r_energy, ENERGY_W'(s_data));
        end
    end

    assign energy_total = r_energy;

endmodule

// File: tb/tb_energy_accumulator.sv
// Directed bench for energy_accumulator with a per-cycle reference model; build with
// PEAK_TRACK_EN defined to also check r_peak.
module tb_energy_accumulator;

    localparam int DATA_W = 8;
    localparam int NUM_CH = 4;
    localparam int WIN    = 16;
    localparam longint SAT = 64'h0000_0000_FFFF_FFFF;
    localparam logic [31:0] PRELOAD = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  s_ch;
    logic [7:0]  s_data;
    logic [7:0]  threshold;
    logic        r_valid;
    logic        r_ready;
    logic [1:0]  r_ch;
    logic [7:0]  r_avg;
    logic        r_alarm;
    logic [31:0] energy_total;
`ifdef PEAK_TRACK_EN
    logic [7:0]  r_peak;
    logic [7:0]  x_peak;
`endif

    // Second instance with three channels so that an out-of-range index is encodable.
    logic        x_valid;
    logic        x_ready;
    logic [1:0]  x_ch;
    logic [7:0]  x_data;
    logic        x_rvalid;
    logic        x_rready;
    logic [1:0]  x_rch;
    logic [7:0]  x_ravg;
    logic        x_ralarm;
    logic [31:0] x_energy;

    always #5 clk = ~clk;

    energy_accumulator #(.DATA_W(8), .NUM_CH(4), .WIN_LOG2(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_ch         (s_ch),
        .s_data       (s_data),
        .threshold    (threshold),
        .r_valid      (r_valid),
        .r_ready      (r_ready),
        .r_ch         (r_ch),
        .r_avg        (r_avg),
        .r_alarm      (r_alarm),
`ifdef PEAK_TRACK_EN
        .r_peak       (r_peak),
`endif
        .energy_total (energy_total)
    );

    energy_accumulator #(.DATA_W(8), .NUM_CH(3), .WIN_LOG2(4)) u_dut3 (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (x_valid),
        .s_ready      (x_ready),
        .s_ch         (x_ch),
        .s_data       (x_data),
        .threshold    (threshold),
        .r_valid      (x_rvalid),
        .r_ready      (x_rready),
        .r_ch         (x_rch),
        .r_avg        (x_ravg),
        .r_alarm      (x_ralarm),
`ifdef PEAK_TRACK_EN
        .r_peak       (x_peak),
`endif
        .energy_total (x_energy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: per-channel window sums, a one-deep result slot, saturating total.
    longint m_sum [NUM_CH];
    int     m_cnt [NUM_CH];
    int     m_max [NUM_CH];
    longint m_energy;
    bit     m_valid;
    int     m_ch, m_avg, m_peak;
    bit     m_alarm;
    bit     m_cons, m_acc;
    int     m_c;
    bit     preload_go = 1'b0;
    bit     cmp_en = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_sum[i] = 0; m_cnt[i] = 0; m_max[i] = 0;
            end
            m_energy = 0; m_valid = 0; m_ch = 0; m_avg = 0; m_alarm = 0; m_peak = 0;
        end else begin
            m_c    = int'(s_ch);
            m_cons = m_valid && r_ready;
            m_acc  = s_valid && (!m_valid || r_ready) && (m_c < NUM_CH);
            if (preload_go) m_energy = longint'(PRELOAD);
            if (m_cons) m_valid = 0;
            if (m_acc) begin
                m_energy = m_energy + longint'(s_data);
                if (m_energy > SAT) m_energy = SAT;
                m_sum[m_c] += longint'(s_data);
                m_cnt[m_c]++;
                if (int'(s_data) > m_max[m_c]) m_max[m_c] = int'(s_data);
                if (m_cnt[m_c] == WIN) begin
                    m_valid = 1;
                    m_ch    = m_c;
                    m_avg   = int'(m_sum[m_c] / WIN);
                    m_alarm = m_avg > int'(threshold);
                    m_peak  = m_max[m_c];
                    m_sum[m_c] = 0; m_cnt[m_c] = 0; m_max[m_c] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            check("r_valid", 64'(r_valid), 64'(m_valid));
            check("s_ready", 64'(s_ready), 64'(!m_valid || r_ready));
            if (m_valid) begin
                check("r_ch", 64'(r_ch), 64'(m_ch));
                check("r_avg", 64'(r_avg), 64'(m_avg));
                check("r_alarm", 64'(r_alarm), 64'(m_alarm));
`ifdef PEAK_TRACK_EN
                check("r_peak", 64'(r_peak), 64'(m_peak));
`endif
            end
            if (!preload_go) check("energy_total", 64'(energy_total), 64'(m_energy));
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input int ch, input int d);
        int n = 0;
        s_valid = 1'b1;
        s_ch    = 2'(ch);
        s_data  = 8'(d);
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_ch = '0; s_data = '0; threshold = 8'd99; r_ready = 1'b1;
        x_valid = 1'b0; x_ch = '0; x_data = '0; x_rready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_r_valid", 64'(r_valid), 64'd0);
        check("reset_energy", 64'(energy_total), 64'd0);
        check("reset_r_avg", 64'(r_avg), 64'd0);
        check("reset_r_ch", 64'(r_ch), 64'd0);
        check("reset_r_alarm", 64'(r_alarm), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cmp_en = 1'b1;

        // 16 x 100 on ch2, threshold 99
        for (int i = 0; i < WIN; i++) send(2, 100);
        @(negedge clk);
        check("s1_r_valid", 64'(r_valid), 64'd1);
        check("s1_r_ch", 64'(r_ch), 64'd2);
        check("s1_r_avg", 64'(r_avg), 64'd100);
        check("s1_r_alarm", 64'(r_alarm), 64'd1);
        check("s1_energy", 64'(energy_total), 64'd1600);
        @(posedge clk); #1;

        // ramp 0..15 on ch0: 120 >> 4 = 7
        for (int i = 0; i < WIN; i++) send(0, i);
        @(negedge clk);
        check("s2_r_avg", 64'(r_avg), 64'd7);
        check("s2_r_ch", 64'(r_ch), 64'd0);
        check("s2_r_alarm", 64'(r_alarm), 64'd0);
`ifdef PEAK_TRACK_EN
        check("s2_r_peak", 64'(r_peak), 64'd15);
`endif
        check("s2_energy", 64'(energy_total), 64'd1720);
        @(posedge clk); #1;

        // interleaved ch0=10 / ch1=200 with backpressure
        r_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 2 * WIN; k++) send(k % 2, (k % 2 == 1) ? 200 : 10);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!r_valid && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check("s3_first_valid", 64'(r_valid), 64'd1);
                check("s3_first_ch", 64'(r_ch), 64'd0);
                check("s3_first_avg", 64'(r_avg), 64'd10);
                check("s3_first_alarm", 64'(r_alarm), 64'd0);
                repeat (3) begin
                    @(negedge clk);
                    check("s3_hold_s_ready", 64'(s_ready), 64'd0);
                    check("s3_hold_avg", 64'(r_avg), 64'd10);
                end
                @(posedge clk); #1;
                r_ready = 1'b1;
                @(posedge clk); #1;
                r_ready = 1'b0;
                @(negedge clk);
                check("s3_second_valid", 64'(r_valid), 64'd1);
                check("s3_second_ch", 64'(r_ch), 64'd1);
                check("s3_second_avg", 64'(r_avg), 64'd200);
                check("s3_second_alarm", 64'(r_alarm), 64'd1);
            end
        join
        @(posedge clk); #1;
        r_ready = 1'b1;
        @(posedge clk); #1;

        // saturation from a forced near-full total
        force dut.r_energy = PRELOAD;
        preload_go = 1'b1;
        #1;
        release dut.r_energy;
        @(posedge clk); #1;
        preload_go = 1'b0;
        send(1, 200);
        @(negedge clk);
        check("s4_energy_below", 64'(energy_total), 64'h0000_0000_FFFF_FFC8);
        @(posedge clk); #1;
        send(1, 200);
        @(negedge clk);
        check("s4_energy_sat", 64'(energy_total), 64'h0000_0000_FFFF_FFFF);
        @(posedge clk); #1;
        send(1, 255);
        @(negedge clk);
        check("s4_energy_stay", 64'(energy_total), 64'h0000_0000_FFFF_FFFF);
        @(posedge clk); #1;

        // reset mid-window on ch3, then a clean window of 50 (equal to threshold: no alarm)
        for (int i = 0; i < 8; i++) send(3, 7);
        rst = 1'b1;
        @(negedge clk);
        check("s5_rst_valid", 64'(r_valid), 64'd0);
        check("s5_rst_energy", 64'(energy_total), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        threshold = 8'd50;
        for (int i = 0; i < WIN; i++) send(3, 50);
        @(negedge clk);
        check("s5_r_valid", 64'(r_valid), 64'd1);
        check("s5_r_avg", 64'(r_avg), 64'd50);
        check("s5_r_alarm", 64'(r_alarm), 64'd0);
        check("s5_energy", 64'(energy_total), 64'd800);
        @(posedge clk); #1;

        // reset while a result is held
        r_ready = 1'b0;
        for (int i = 0; i < WIN; i++) send(0, 1);
        @(negedge clk);
        check("s6_held", 64'(r_valid), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("s6_rst_drop", 64'(r_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        r_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // illegal channel on the three-channel instance
        x_valid = 1'b1; x_ch = 2'd3; x_data = 8'd77;
        repeat (4) begin
            @(negedge clk);
            check("s7_illegal_ready", 64'(x_ready), 64'd1);
            check("s7_illegal_energy", 64'(x_energy), 64'd0);
            check("s7_illegal_valid", 64'(x_rvalid), 64'd0);
        end
        @(posedge clk); #1;
        x_ch = 2'd2; x_data = 8'd5;
        repeat (WIN) @(posedge clk);
        #1;
        x_valid = 1'b0;
        @(negedge clk);
        check("s7_legal_valid", 64'(x_rvalid), 64'd1);
        check("s7_legal_ch", 64'(x_rch), 64'd2);
        check("s7_legal_avg", 64'(x_ravg), 64'd5);
        check("s7_legal_energy", 64'(x_energy), 64'd80);
        @(posedge clk); #1;

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
